// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// State encoding, byte-lane geometry and write-size clamping.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int         LANE_W     = 8;
  localparam int         LANES      = 8;
  localparam logic [3:0] SIZE_CLAMP = 4'd8;

  function automatic logic [3:0] clamp_size(input logic [7:0] size);
    return (size > 8'(SIZE_CLAMP)) ? SIZE_CLAMP : size[3:0];
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// rmem request / data-phase bundle between a memory-stage initiator and the responder.
// Request side is valid/ready; read data returns as one held beat with dp_valid/dp_ready.
interface dmem_responder_if #(
  parameter int DDATAW = 64,
  parameter int DSIZEW = 4,
  parameter int DADDRW = 32
);

  logic              rmem_valid;
  logic              rmem_ready;
  logic [DADDRW-1:0] rmem_address;
  logic              rmem_wr_en;
  logic [DDATAW-1:0] rmem_wr_data;
  logic [DSIZEW-1:0] rmem_wr_size;
  logic              rmem_dp_valid;
  logic              rmem_dp_ready;
  logic [DDATAW-1:0] rmem_dp_read_data;

  modport master (
    output rmem_valid,
    output rmem_address,
    output rmem_wr_en,
    output rmem_wr_data,
    output rmem_wr_size,
    output rmem_dp_ready,
    input  rmem_ready,
    input  rmem_dp_valid,
    input  rmem_dp_read_data
  );

  modport slave (
    input  rmem_valid,
    input  rmem_address,
    input  rmem_wr_en,
    input  rmem_wr_data,
    input  rmem_wr_size,
    input  rmem_dp_ready,
    output rmem_ready,
    output rmem_dp_valid,
    output rmem_dp_read_data
  );

endinterface

// File: rtl/dmem_byte_lane_merge.sv
// Combinational byte-lane steering: write enables/data for the low and high word, and read reassembly.
// Zero latency; no flow control of its own.
module dmem_byte_lane_merge
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [3:0]  nbytes,
  input  logic [63:0] wr_data,
  input  logic [63:0] lo_word,
  input  logic [63:0] hi_word,
  output logic        split,
  output logic [7:0]  lo_be,
  output logic [7:0]  hi_be,
  output logic [63:0] lo_wdata,
  output logic [63:0] hi_wdata,
  output logic [63:0] rd_data
);

  logic [4:0]   end_byte;
  logic [6:0]   shamt;
  logic [127:0] wr_wide;

  always_comb begin
    end_byte = 5'(off) + 5'(nbytes);
    split    = end_byte > 5'(LANES);
    shamt    = {1'b0, off, 3'b000};
    lo_be    = '0;
    hi_be    = '0;
    // Bytes at or past lane 8 of the access spill into the following word.
    for (int i = 0; i < LANES; i++) begin
      lo_be[i] = (5'(i) >= 5'(off)) && (5'(i) < end_byte);
      hi_be[i] = (5'(i) + 5'(LANES)) < end_byte;
    end
    wr_wide  = {64'b0, wr_data} << shamt;
    lo_wdata = wr_wide[63:0];
    hi_wdata = wr_wide[127:64];
    rd_data  = 64'({hi_word, lo_word} >> shamt);
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, byte-addressed little-endian access to a 64-bit word array.
// Read beat LATENCY cycles after accept (+1 when split); beat held until dp_ready, no accepts meanwhile.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DDATAW   = 64,
  parameter int DSIZEW   = 4,
  parameter int DADDRW   = 32,
  parameter int MEMWORDS = 1024,
  parameter int LATENCY  = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave rmem
);

  localparam int IDXW = $clog2(MEMWORDS);
  localparam int CNTW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic [DADDRW-1:0] addr_in;
  logic [DSIZEW-1:0] size_in;
  logic [IDXW-1:0]   idx_in;

  logic [IDXW-1:0]   idx_q;
  logic [IDXW-1:0]   idx_hi;
  logic [IDXW-1:0]   mem_idx;
  logic [2:0]        off_q;
  logic              wr_en_q;
  logic [DDATAW-1:0] wr_data_q;
  logic [3:0]        nbytes_q;
  logic [CNTW-1:0]   cnt_q;
  logic [DDATAW-1:0] lo_word_q;
  logic [DDATAW-1:0] rdata_q;

  logic [DDATAW-1:0] mem [MEMWORDS];
  logic [DDATAW-1:0] mem_rd;
  logic [DDATAW-1:0] merge_lo;
  logic              split;
  logic [7:0]        lo_be;
  logic [7:0]        hi_be;
  logic [DDATAW-1:0] lo_wdata;
  logic [DDATAW-1:0] hi_wdata;
  logic [DDATAW-1:0] rd_data;

  assign addr_in = rmem.rmem_address;
  assign size_in = rmem.rmem_wr_size;
  assign idx_in  = IDXW'(addr_in[DADDRW-1:3] % (DADDRW-3)'(MEMWORDS));

  assign rmem.rmem_ready        = (state == ST_IDLE) && !reset;
  assign rmem.rmem_dp_valid     = (state == ST_RESP);
  assign rmem.rmem_dp_read_data = rdata_q;
  assign accept                 = rmem.rmem_valid && rmem.rmem_ready;

  // The index naturally wraps to word 0 past the end of the array.
  assign idx_hi   = idx_q + 1'b1;
  assign mem_idx  = (state == ST_HI) ? idx_hi : idx_q;
  assign mem_rd   = mem[mem_idx];
  assign merge_lo = (state == ST_HI) ? lo_word_q : mem_rd;

  dmem_byte_lane_merge u_merge (
    .off      (off_q),
    .nbytes   (nbytes_q),
    .wr_data  (wr_data_q),
    .lo_word  (merge_lo),
    .hi_word  (mem_rd),
    .split    (split),
    .lo_be    (lo_be),
    .hi_be    (hi_be),
    .lo_wdata (lo_wdata),
    .hi_wdata (hi_wdata),
    .rd_data  (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_LO;
      end
      ST_LO: begin
        if (split)             state_nxt = ST_HI;
        else if (LATENCY == 1) state_nxt = wr_en_q ? ST_IDLE : ST_RESP;
        else                   state_nxt = ST_WAIT;
      end
      ST_HI: begin
        if (LATENCY == 1) state_nxt = wr_en_q ? ST_IDLE : ST_RESP;
        else              state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_nxt = wr_en_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (rmem.rmem_dp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q     <= '0;
      off_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      nbytes_q  <= '0;
      cnt_q     <= '0;
      lo_word_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        idx_q     <= idx_in;
        off_q     <= addr_in[2:0];
        wr_en_q   <= rmem.rmem_wr_en;
        wr_data_q <= rmem.rmem_wr_data;
        nbytes_q  <= rmem.rmem_wr_en ? clamp_size(8'(size_in)) : SIZE_CLAMP;
      end
      if (state != ST_WAIT && state_nxt == ST_WAIT) begin
        cnt_q <= CNTW'(LATENCY - 2);
      end else if (state == ST_WAIT) begin
        cnt_q <= cnt_q - CNTW'(1);
      end
      // The beat register only moves while assembling, so it stays frozen through RESP.
      if (!wr_en_q) begin
        if (state == ST_LO && split) lo_word_q <= mem_rd;
        if ((state == ST_LO && !split) || state == ST_HI) rdata_q <= rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_en_q) begin
      for (int b = 0; b < LANES; b++) begin
        if (state == ST_LO && lo_be[b]) mem[idx_q][b*LANE_W +: LANE_W] <= lo_wdata[b*LANE_W +: LANE_W];
        if (state == ST_HI && hi_be[b]) mem[idx_hi][b*LANE_W +: LANE_W] <= hi_wdata[b*LANE_W +: LANE_W];
      end
    end
  end

endmodule
